// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor
// Bit-serial a - b (LSB first, one bit per clock) through a single
// full-subtractor cell. Define SERIAL_SUB_BORROW_IN_EN to add a borrow-in port.
// Rev    : 1.0
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
   input  logic             bin,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bo,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-2:0]   r_work;
   logic               r_borrow;
   logic [CW-1:0]      r_count;

   logic               w_x;
   logic               w_y;
   logic               w_d;
   logic               w_bnext;
   logic               w_last;
   logic               w_bin_init;
   logic [WIDTH-1:0]   w_full;

   assign w_x     = r_a[0];
   assign w_y     = r_b[0];
   assign w_d     = w_x ^ w_y ^ r_borrow;
   assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
   assign w_last  = (r_count == CW'(WIDTH - 1));
   // New difference bit enters at the MSB; after the last bit this is the result
   assign w_full  = {w_d, r_work};

`ifdef SERIAL_SUB_BORROW_IN_EN
   assign w_bin_init = bin;
`else
   assign w_bin_init = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_work   <= '0;
         r_borrow <= 1'b0;
         r_count  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff     <= '0;
         bo       <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= w_bin_init;
                  r_count  <= '0;
                  r_work   <= '0;
                  busy     <= 1'b1;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_a      <= r_a >> 1;
               r_b      <= r_b >> 1;
               r_borrow <= w_bnext;
               if (w_last) begin
                  // w_x / w_y are the operand sign bits on this final edge
                  diff    <= w_full;
                  bo      <= w_bnext;
                  ovf     <= (w_x ^ w_y) & (w_d ^ w_x);
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_work  <= w_full[WIDTH-1:1];
                  r_count <= r_count + CW'(1);
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
